marker_ctrl: RTL and testbench
==============================

# marker_ctrl

Scheduler for the object-marker overlay. Two centroid producers (trackers) offer object positions over valid/ready handshakes. The block buffers one update per producer and commits exactly one of them per frame, only during vertical blanking, so the marker never tears mid-frame. It drives the object-center, enable and status inputs of the marker colouring stage, and blanks the marker when no fresh position has arrived for a configurable number of frames.

## Interface
- DISP_WIDTH, 11, width of all coordinates
- H_ACTIVE, 640, active pixels per line; accepted x is clamped to H_ACTIVE-1
- V_ACTIVE, 480, active lines per frame; accepted y is clamped to V_ACTIVE-1
- STALE_FRAMES, 4, consecutive commits without data before the marker is disabled (1..15)

Ports:
- clk  in  1  system/pixel clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the first active pixel of a frame
- frame_end  in  1  one-cycle pulse after the last active pixel of a frame
- mode  in  2  00 off, 01 source 0 only, 10 source 1 only, 11 round-robin
- s0_valid, s1_valid  in  1  producer offers a position
- s0_ready, s1_ready  out  1  block can accept; equals NOT pending-valid of that source
- s0_x, s0_y, s1_x, s1_y  in  DISP_WIDTH  offered coordinates
- x_obj, y_obj  out  DISP_WIDTH  committed object center
- marker_en  out  1  marker overlay enable
- active_src  out  1  source of the last committed position
- stale  out  1  high while the stale counter is at STALE_FRAMES

## Operation
- Per-source pending register: {pend_valid, x, y}.
  - Transfer occurs when sN_valid & sN_ready.
  - On transfer: x stored as min(sN_x, H_ACTIVE-1), y as min(sN_y, V_ACTIVE-1); pend_valid set.
- FSM states: IDLE, ACTIVE, COMMIT, BLANK.
  - IDLE: on frame_start go to ACTIVE; frame_end ignored.
  - ACTIVE: on frame_end go to COMMIT; frame_start ignored.
  - COMMIT: exactly one cycle, then BLANK.
  - BLANK: on frame_start go to ACTIVE.
- Transfers are accepted in every state; only COMMIT changes the outputs.
- mode is sampled only in COMMIT.
- COMMIT selection:
  - mode 01: use source 0 if pending; discard any source 1 pending.
  - mode 10: use source 1 if pending; discard any source 0 pending.
  - mode 11: prefer rr_ptr; if that source is empty, use the other. After a selection, rr_ptr = NOT source used. With no selection, rr_ptr is unchanged and nothing is discarded.
  - mode 00: discard both pendings; marker_en=0, stale=0, stale counter cleared.
- On a selection in modes 01/10/11:
  - x_obj/y_obj load the pending values; active_src = source used.
  - Used pend_valid cleared; stale counter cleared; marker_en=1; stale=0.
- No selection in modes 01/10/11:
  - Stale counter increments, saturating at STALE_FRAMES.
  - When it reaches STALE_FRAMES: marker_en=0, stale=1; x_obj/y_obj hold.
- Counter width is 4 bits.
- Clamping uses an unsigned compare only; no wrap.

## Timing
- Reset (asynchronous, immediate) values:
  - state IDLE; pend_valid 0 for both sources, so s0_ready = s1_ready = 1.
  - x_obj, y_obj, stale counter, rr_ptr = 0.
  - marker_en, active_src, stale = 0.
- Reset mid-frame or mid-COMMIT discards all pending data. The first commit after reset requires frame_start then frame_end.
- Latency:
  - frame_end sampled at edge t puts the FSM in COMMIT for cycle t..t+1.
  - Outputs update at edge t+1.
  - Outputs are constant from then until the next COMMIT, so they are stable over the whole next active frame.
- Handshake:
  - sN_ready is combinational from pend_valid only; it does not depend on sN_valid.
  - A pending clear at edge t+1 raises ready during cycle t+1. The earliest new transfer is at edge t+2.
  - Data offered while ready=0 is not taken; the producer holds it (standard valid/ready).
- A frame_start and frame_end in the same cycle are resolved by the current state: ACTIVE honours only frame_end, IDLE/BLANK only frame_start.
- A transfer and a COMMIT can occur in the same cycle on different sources with no interaction.

## Test plan
- Reset, then s0 offers (700, 500) in IDLE -> s0_ready drops next cycle; after frame_start+frame_end in mode 01: x_obj=639, y_obj=479, marker_en=1, active_src=0, one cycle after COMMIT.
- Mode 11, both sources pending, s0=(10,20), s1=(30,40), rr_ptr=0 -> frame 1 commits (10,20) src 0; frame 2 commits (30,40) src 1; both ready return high the cycle after their commit.
- Mode 11, only s1 pending, rr_ptr=0 -> commits s1, rr_ptr becomes 0; s0 pending untouched in a later frame.
- Mode 01, no new data for 4 frames after a commit -> marker_en stays 1 through 3 empty commits; 4th empty commit gives marker_en=0, stale=1, x_obj unchanged; a new s0 update clears stale.
- Mode 10 with s0 pending -> s0 pending discarded at COMMIT (s0_ready high the next cycle); mode 00 -> marker_en=0 at COMMIT, both pendings cleared.
- areset pulsed during ACTIVE with both pendings full -> all outputs 0 immediately; both readys high; frame_end before any frame_start produces no commit.

Source files
------------

// File: rtl/marker_ctrl.sv
// Marker overlay scheduler: buffers one centroid per tracker and commits at most one
// per frame during vertical blanking, blanking the marker after a run of empty frames.
module marker_ctrl #(
  parameter int DISP_WIDTH   = 11,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int STALE_FRAMES = 4
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic [1:0]            mode,
  input  logic                  s0_valid,
  input  logic                  s1_valid,
  output logic                  s0_ready,
  output logic                  s1_ready,
  input  logic [DISP_WIDTH-1:0] s0_x,
  input  logic [DISP_WIDTH-1:0] s0_y,
  input  logic [DISP_WIDTH-1:0] s1_x,
  input  logic [DISP_WIDTH-1:0] s1_y,
  output logic [DISP_WIDTH-1:0] x_obj,
  output logic [DISP_WIDTH-1:0] y_obj,
  output logic                  marker_en,
  output logic                  active_src,
  output logic                  stale
);

  typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT, BLANK} state_t;

  localparam logic [DISP_WIDTH-1:0] X_MAX = DISP_WIDTH'(H_ACTIVE - 1);
  localparam logic [DISP_WIDTH-1:0] Y_MAX = DISP_WIDTH'(V_ACTIVE - 1);
  localparam logic [3:0]            STALE_MAX = 4'(STALE_FRAMES);

  state_t                state_q, state_d;
  logic                  pv0_q, pv0_d, pv1_q, pv1_d;
  logic [DISP_WIDTH-1:0] px0_q, px0_d, py0_q, py0_d;
  logic [DISP_WIDTH-1:0] px1_q, px1_d, py1_q, py1_d;
  logic [DISP_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic                  en_q, en_d, src_q, src_d, stale_q, stale_d, rr_q, rr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  xfer0, xfer1, use0, use1, drop0, drop1;

  function automatic logic [DISP_WIDTH-1:0] clamp(input logic [DISP_WIDTH-1:0] v,
                                                   input logic [DISP_WIDTH-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign xfer0 = s0_valid & ~pv0_q;
  assign xfer1 = s1_valid & ~pv1_q;

  always_comb begin
    state_d = state_q;
    pv0_d   = pv0_q;
    pv1_d   = pv1_q;
    px0_d   = px0_q;
    py0_d   = py0_q;
    px1_d   = px1_q;
    py1_d   = py1_q;
    x_d     = x_q;
    y_d     = y_q;
    en_d    = en_q;
    src_d   = src_q;
    stale_d = stale_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    use0    = 1'b0;
    use1    = 1'b0;
    drop0   = 1'b0;
    drop1   = 1'b0;

    unique case (state_q)
      IDLE:    if (frame_start) state_d = ACTIVE;
      ACTIVE:  if (frame_end)   state_d = COMMIT;
      COMMIT:  state_d = BLANK;
      BLANK:   if (frame_start) state_d = ACTIVE;
      default: state_d = IDLE;
    endcase

    if (state_q == COMMIT) begin
      unique case (mode)
        2'b00: begin
          drop0   = 1'b1;
          drop1   = 1'b1;
          en_d    = 1'b0;
          stale_d = 1'b0;
          cnt_d   = 4'd0;
        end
        2'b01: begin
          use0  = pv0_q;
          drop1 = 1'b1;
        end
        2'b10: begin
          use1  = pv1_q;
          drop0 = 1'b1;
        end
        default: begin
          if (!rr_q) begin
            use0 = pv0_q;
            use1 = ~pv0_q & pv1_q;
          end else begin
            use1 = pv1_q;
            use0 = ~pv1_q & pv0_q;
          end
        end
      endcase

      if (use0 || use1) begin
        x_d     = use1 ? px1_q : px0_q;
        y_d     = use1 ? py1_q : py0_q;
        src_d   = use1;
        cnt_d   = 4'd0;
        en_d    = 1'b1;
        stale_d = 1'b0;
        if (mode == 2'b11) rr_d = ~use1;
      end else if (mode != 2'b00) begin
        if (cnt_q != STALE_MAX) cnt_d = cnt_q + 4'd1;
        if (cnt_d == STALE_MAX) begin
          en_d    = 1'b0;
          stale_d = 1'b1;
        end
      end
    end

    // A fresh transfer always lands in an empty slot, so it overrides any discard.
    if (use0 || drop0) pv0_d = 1'b0;
    if (use1 || drop1) pv1_d = 1'b0;
    if (xfer0) begin
      pv0_d = 1'b1;
      px0_d = clamp(s0_x, X_MAX);
      py0_d = clamp(s0_y, Y_MAX);
    end
    if (xfer1) begin
      pv1_d = 1'b1;
      px1_d = clamp(s1_x, X_MAX);
      py1_d = clamp(s1_y, Y_MAX);
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      pv0_q   <= 1'b0;
      pv1_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      en_q    <= 1'b0;
      src_q   <= 1'b0;
      stale_q <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      pv0_q   <= pv0_d;
      pv1_q   <= pv1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      en_q    <= en_d;
      src_q   <= src_d;
      stale_q <= stale_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pending coordinates are qualified by pv*_q, so they need no reset.
  always_ff @(posedge clk) begin
    px0_q <= px0_d;
    py0_q <= py0_d;
    px1_q <= px1_d;
    py1_q <= py1_d;
  end

  assign s0_ready   = ~pv0_q;
  assign s1_ready   = ~pv1_q;
  assign x_obj      = x_q;
  assign y_obj      = y_q;
  assign marker_en  = en_q;
  assign active_src = src_q;
  assign stale      = stale_q;

endmodule

// File: tb/tb_marker_ctrl.sv
// Directed bench for marker_ctrl: commit scheduling, clamping, round-robin, staleness, reset.
module tb_marker_ctrl;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic         frame_start = 1'b0, frame_end = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         s0_valid = 1'b0, s1_valid = 1'b0;
  logic         s0_ready, s1_ready;
  logic [W-1:0] s0_x = '0, s0_y = '0, s1_x = '0, s1_y = '0;
  logic [W-1:0] x_obj, y_obj;
  logic         marker_en, active_src, stale;

  int tests = 0;
  int fails = 0;

  marker_ctrl dut (
    .clk(clk), .areset(areset), .frame_start(frame_start), .frame_end(frame_end),
    .mode(mode), .s0_valid(s0_valid), .s1_valid(s1_valid),
    .s0_ready(s0_ready), .s1_ready(s1_ready),
    .s0_x(s0_x), .s0_y(s0_y), .s1_x(s1_x), .s1_y(s1_y),
    .x_obj(x_obj), .y_obj(y_obj), .marker_en(marker_en),
    .active_src(active_src), .stale(stale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v0, input logic [W-1:0] x0, input logic [W-1:0] y0,
                       input logic v1, input logic [W-1:0] x1, input logic [W-1:0] y1);
    s0_valid = v0; s0_x = x0; s0_y = y0;
    s1_valid = v1; s1_x = x1; s1_y = y1;
    tick();
    s0_valid = 1'b0;
    s1_valid = 1'b0;
  endtask

  // Full frame; returns one cycle after the COMMIT edge.
  task automatic frame();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick(); tick();
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    tick();
  endtask

  initial begin
    tick(); tick();
    areset = 1'b0;
    tick();
    chk("rst_x", x_obj, 0);
    chk("rst_y", y_obj, 0);
    chk("rst_en", marker_en, 0);
    chk("rst_src", active_src, 0);
    chk("rst_stale", stale, 0);
    chk("rst_rdy0", s0_ready, 1);
    chk("rst_rdy1", s1_ready, 1);

    // Clamping through mode 01, with commit latency check.
    mode = 2'b01;
    offer(1, 700, 500, 0, 0, 0);
    chk("clamp_rdy0_low", s0_ready, 0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick();
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    chk("latency_en_old", marker_en, 0);
    tick();
    chk("clamp_x", x_obj, 639);
    chk("clamp_y", y_obj, 479);
    chk("clamp_en", marker_en, 1);
    chk("clamp_src", active_src, 0);
    chk("clamp_rdy0", s0_ready, 1);

    // Round-robin with both pending, rr starts at 0.
    mode = 2'b11;
    offer(1, 10, 20, 1, 30, 40);
    frame();
    chk("rr1_x", x_obj, 10);
    chk("rr1_y", y_obj, 20);
    chk("rr1_src", active_src, 0);
    chk("rr1_rdy0", s0_ready, 1);
    chk("rr1_rdy1", s1_ready, 0);
    frame();
    chk("rr2_x", x_obj, 30);
    chk("rr2_y", y_obj, 40);
    chk("rr2_src", active_src, 1);
    chk("rr2_rdy1", s1_ready, 1);

    // Only s1 pending with rr=0 -> s1 used, rr becomes 0 again.
    offer(0, 0, 0, 1, 100, 200);
    frame();
    chk("rrs1_x", x_obj, 100);
    chk("rrs1_src", active_src, 1);
    offer(1, 50, 60, 1, 70, 80);
    frame();
    chk("rrptr_x", x_obj, 50);
    chk("rrptr_src", active_src, 0);
    chk("rrptr_rdy1_held", s1_ready, 0);
    frame();
    chk("rrnext_x", x_obj, 70);
    chk("rrnext_src", active_src, 1);

    // Staleness in mode 01.
    mode = 2'b01;
    offer(1, 5, 6, 0, 0, 0);
    frame();
    chk("st0_x", x_obj, 5);
    for (int i = 1; i <= 3; i++) begin
      frame();
      chk("st_en_hold", marker_en, 1);
      chk("st_flag_low", stale, 0);
    end
    frame();
    chk("st4_en", marker_en, 0);
    chk("st4_stale", stale, 1);
    chk("st4_x", x_obj, 5);
    frame();
    chk("st5_stale", stale, 1);
    offer(1, 7, 8, 0, 0, 0);
    frame();
    chk("st_new_x", x_obj, 7);
    chk("st_new_en", marker_en, 1);
    chk("st_new_stale", stale, 0);

    // Mode 10 discards s0; mode 00 discards both and blanks.
    offer(1, 1, 2, 0, 0, 0);
    mode = 2'b10;
    frame();
    chk("m10_rdy0", s0_ready, 1);
    chk("m10_x", x_obj, 7);
    chk("m10_en", marker_en, 1);
    offer(1, 3, 4, 1, 9, 9);
    chk("m00_pre_rdy0", s0_ready, 0);
    mode = 2'b00;
    frame();
    chk("m00_en", marker_en, 0);
    chk("m00_stale", stale, 0);
    chk("m00_rdy0", s0_ready, 1);
    chk("m00_rdy1", s1_ready, 1);
    chk("m00_x", x_obj, 7);

    // Asynchronous reset during ACTIVE.
    mode = 2'b10;
    offer(0, 0, 0, 1, 11, 12);
    frame();
    chk("pre_rst_src", active_src, 1);
    chk("pre_rst_x", x_obj, 11);
    offer(1, 20, 21, 1, 22, 23);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick();
    areset = 1'b1;
    #1;
    chk("arst_x", x_obj, 0);
    chk("arst_y", y_obj, 0);
    chk("arst_en", marker_en, 0);
    chk("arst_src", active_src, 0);
    chk("arst_rdy0", s0_ready, 1);
    chk("arst_rdy1", s1_ready, 1);
    tick();
    areset = 1'b0;
    mode = 2'b01;
    offer(1, 33, 44, 0, 0, 0);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    tick(); tick();
    chk("noframe_x", x_obj, 0);
    chk("noframe_en", marker_en, 0);
    frame();
    chk("post_rst_x", x_obj, 33);
    chk("post_rst_y", y_obj, 44);
    chk("post_rst_en", marker_en, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
